// File: rtl/call_stack_if.sv
// Bundled request/status signals of the 16-deep, 8-bit return-address stack.
// The master side drives requests; the slave side (the stack) drives status and top-of-stack.
interface call_stack_if;
    logic       Push;
    logic       Pop;
    logic       Clear;
    logic [7:0] Value;
    logic       Disable;
    logic [7:0] Output;
    logic [4:0] Count;
    logic       Empty;
    logic       Full;
    logic       Error;

    modport master (
        output Push, Pop, Clear, Value, Disable,
        input  Output, Count, Empty, Full, Error
    );

    modport slave (
        input  Push, Pop, Clear, Value, Disable,
        output Output, Count, Empty, Full, Error
    );
endinterface

// File: rtl/call_stack.sv
// 16 x 8-bit hardware call stack with a sticky overflow/underflow flag.
// Status and top-of-stack are decoded combinationally from the registered pointer and storage.
module call_stack #(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input logic        clk,
    input logic        rst,
    call_stack_if.slave bus
);

    localparam logic [4:0] DEPTH     = 5'd16;
    localparam logic [7:0] ID_BYTE   = 8'(UUID);
    localparam int         NAME_BITS = $bits(NAME);

    logic [7:0] mem_r [16];
    logic [4:0] sp_r;
    logic       error_r;

    logic [4:0] sp_nxt_s;
    logic       error_nxt_s;
    logic       wr_en_s;
    logic [3:0] wr_addr_s;
    logic [4:0] sp_m1_s;
    logic [3:0] top_idx_s;
    logic       empty_s;
    logic       full_s;
    logic [7:0] top_data_s;
    logic       unused_cfg_s;

    assign unused_cfg_s = ^{ID_BYTE, NAME_BITS[0]};

    // Status decode; a pointer at or beyond DEPTH is treated as full so it can never advance further.
    always_comb begin
        sp_m1_s   = sp_r - 5'd1;
        top_idx_s = sp_m1_s[3:0];
        empty_s   = (sp_r == 5'd0);
        full_s    = (sp_r >= DEPTH);
        if (empty_s) begin
            top_data_s = 8'h00;
        end else begin
            top_data_s = mem_r[top_idx_s];
        end
    end

    // Next-state selection: Clear dominates, then the Push/Pop combination.
    always_comb begin
        sp_nxt_s    = sp_r;
        error_nxt_s = error_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = 4'd0;
        if (bus.Clear) begin
            sp_nxt_s    = 5'd0;
            error_nxt_s = 1'b0;
        end else begin
            case ({bus.Push, bus.Pop})
                2'b10: begin
                    if (full_s) begin
                        error_nxt_s = 1'b1;
                    end else begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = sp_r[3:0];
                        sp_nxt_s  = sp_r + 5'd1;
                    end
                end
                2'b01: begin
                    if (empty_s) begin
                        error_nxt_s = 1'b1;
                    end else begin
                        sp_nxt_s = sp_m1_s;
                    end
                end
                2'b11: begin
                    // Replace-top leaves the pointer alone, so it is legal even when full.
                    if (empty_s) begin
                        error_nxt_s = 1'b1;
                    end else begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = top_idx_s;
                    end
                end
                default: begin
                    sp_nxt_s    = sp_r;
                    error_nxt_s = error_r;
                end
            endcase
        end
    end

    // Pointer and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_r    <= 5'd0;
            error_r <= 1'b0;
        end else begin
            sp_r    <= sp_nxt_s;
            error_r <= error_nxt_s;
        end
    end

    // Entry storage; no reset needed because Empty gates the output, but writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (rst && wr_en_s) begin
            mem_r[wr_addr_s] <= bus.Value;
        end
    end

    // Output gating and status drive.
    always_comb begin
        if (bus.Disable) begin
            bus.Output = 8'h00;
        end else begin
            bus.Output = top_data_s;
        end
        bus.Count = sp_r;
        bus.Empty = empty_s;
        bus.Full  = full_s;
        bus.Error = error_r;
    end

endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack: stimulus pushes predicted status into a queue,
// a monitor pops and compares one entry per clock; reference model is a byte queue.
module tb_call_stack;

    logic clk;
    logic rst;
    call_stack_if bus ();

    call_stack #(.UUID(3), .NAME("u_cs")) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    byte unsigned stk[$];
    bit           err_m;
    logic [15:0]  exp_q[$];

    function automatic logic [15:0] predict(input bit dis);
        logic [7:0] o;
        logic [4:0] c;
        if (dis || stk.size() == 0) o = 8'h00;
        else                        o = stk[stk.size() - 1];
        c = 5'(stk.size());
        return {o, c, stk.size() == 0, stk.size() == 16, err_m};
    endfunction

    function automatic void model_step(input bit p, input bit q, input bit c, input byte unsigned v);
        int n;
        n = stk.size();
        if (c) begin
            stk.delete();
            err_m = 1'b0;
        end else if (p && q) begin
            if (n == 0) err_m = 1'b1;
            else        stk[n - 1] = v;
        end else if (p) begin
            if (n == 16) err_m = 1'b1;
            else         stk.push_back(v);
        end else if (q) begin
            if (n == 0) err_m = 1'b1;
            else        void'(stk.pop_back());
        end
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got out=%h cnt=%0d e=%b f=%b err=%b, want out=%h cnt=%0d e=%b f=%b err=%b",
                     name, act[15:8], act[7:3], act[2], act[1], act[0],
                     exp[15:8], exp[7:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [15:0] dut_status();
        return {bus.Output, bus.Count, bus.Empty, bus.Full, bus.Error};
    endfunction

    // One clock of stimulus; Disable stays put until the next negedge so the monitor sees it.
    task automatic step(input bit p, input bit q, input bit c, input byte unsigned v, input bit d);
        @(negedge clk);
        bus.Push    = p;
        bus.Pop     = q;
        bus.Clear   = c;
        bus.Value   = v;
        bus.Disable = d;
        @(posedge clk);
        model_step(p, q, c, v);
        exp_q.push_back(predict(d));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        bus.Push = 1'b0;
        bus.Pop  = 1'b0;
        bus.Clear = 1'b0;
        bus.Disable = 1'b0;
        #2 rst = 1'b0;
        stk.delete();
        err_m = 1'b0;
        #1 check("async_reset", dut_status(), predict(1'b0));
        #1 rst = 1'b1;
    endtask

    // Monitor: every rising edge with a pending prediction is compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) check("cycle", dut_status(), exp_q.pop_front());
        end
    end

    initial begin
        int guard;
        bit p, q, c, d;
        bus.Push = 1'b0; bus.Pop = 1'b0; bus.Clear = 1'b0;
        bus.Value = 8'h00; bus.Disable = 1'b0;
        rst = 1'b0;
        err_m = 1'b0;
        #3;
        check("reset_state", dut_status(), {8'h00, 5'd0, 1'b1, 1'b0, 1'b0});
        #4 rst = 1'b1;

        // basic push/pop
        step(1, 0, 0, 8'h11, 0);
        step(1, 0, 0, 8'h22, 0);
        step(1, 0, 0, 8'h33, 0);
        step(0, 1, 0, 8'h00, 0);
        // fill to 16, then overflow
        step(0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i), 0);
        step(1, 0, 0, 8'hAA, 0);
        step(1, 1, 0, 8'h77, 0);
        step(0, 1, 0, 8'h00, 0);
        // underflow, clear, push
        step(0, 0, 1, 8'h00, 0);
        step(0, 1, 0, 8'h00, 0);
        step(1, 1, 0, 8'h66, 0);
        step(0, 0, 1, 8'h00, 0);
        step(1, 0, 0, 8'h5A, 0);
        // replace top
        step(1, 0, 0, 8'h22, 0);
        step(1, 1, 0, 8'h99, 0);
        step(0, 1, 0, 8'h00, 0);
        // disable gating does not block operations
        step(0, 0, 1, 8'h00, 0);
        step(1, 0, 0, 8'h44, 0);
        step(0, 0, 0, 8'h00, 1);
        step(1, 0, 0, 8'h55, 1);
        step(0, 0, 0, 8'h00, 0);
        // reset with count 5 and error set
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h80 + i), 0);
        step(0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hC0 + i), 0);
        step(1, 1, 0, 8'hEE, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hD0 + i), 0);
        pulse_reset();
        step(1, 0, 0, 8'h01, 0);

        // randomized traffic with drifting push/pop bias so both boundaries get exercised
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(99) < bias);
            q = ($urandom_range(99) < (100 - bias));
            c = ($urandom_range(99) < 2);
            d = ($urandom_range(99) < 15);
            step(p, q, c, 8'($urandom), d);
            if ($urandom_range(999) < 3) pulse_reset();
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got pending=%0d, want pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 The module SHALL have parameter UUID, default 0, meaning a per-instance identifier XORed into child identifiers.
REQ-002 The module SHALL have parameter NAME, default "", meaning a instance label with no functional effect.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst  input  1  Reset, asynchronous and active-low.
REQ-005 Push  input  [0:0]  Request to push Value this cycle.
REQ-006 Pop  input  [0:0]  Request to pop the top entry this cycle.
REQ-007 Clear  input  [0:0]  Synchronous empty-and-clear-error request.
REQ-008 Value  input  [7:0]  Data to push, typically a return address.
REQ-009 Disable  input  [0:0]  Forces Output to zero; Output is a data source for the downstream 8-way operand mux.
REQ-010 Output  output  [7:0]  Current top-of-stack, gated.
REQ-011 Count  output  [4:0]  Number of valid entries, 0..16.
REQ-012 Empty  output  [0:0]  High when Count == 0.
REQ-013 Full  output  [0:0]  High when Count == 16.
REQ-014 Error  output  [0:0]  Sticky overflow/underflow flag.

Function
REQ-015 Storage SHALL be 16 entries x 8 bits plus a 5-bit stack pointer SP equal to Count.
REQ-016 Output SHALL be combinational: 0 when Disable=1 or Empty=1, else entry[SP-1].
REQ-017 Output, Count, Empty and Full SHALL be combinational from registered state, so the effect of an operation is visible the cycle after the edge that performs it (latency 1).
REQ-018 Operation priority per edge SHALL be: Clear, then Push/Pop.
REQ-019 Clear=1 SHALL set SP=0 and Error=0, ignoring Push/Pop; entry contents are don't-care.
REQ-020 Push only, not Full: entry[SP] <= Value, SP <= SP+1.
REQ-021 Push only, Full: no write, SP unchanged, Error <= 1.
REQ-022 Pop only, not Empty: SP <= SP-1; the popped value is the Output presented before the edge.
REQ-023 Pop only, Empty: SP unchanged, Error <= 1.
REQ-024 Push and Pop, not Empty: entry[SP-1] <= Value (replace top), SP unchanged, including when Full.
REQ-025 Push and Pop, Empty: no write, SP unchanged, Error <= 1.
REQ-026 Neither Push nor Pop: state SHALL hold.
REQ-027 Error SHALL, once set, stay 1 until Clear or reset; erroneous requests SHALL NOT corrupt SP or stored entries.
REQ-028 Disable SHALL gate Output only and SHALL NOT block Push, Pop or Clear.
REQ-029 SP SHALL never exceed 16 or wrap below 0.

Reset
REQ-030 rst low SHALL asynchronously force SP=0 and Error=0, giving Output=0, Count=0, Empty=1, Full=0, Error=0 regardless of clk.
REQ-031 Entry contents SHALL NOT require reset; the Empty gating keeps Output at 0.
REQ-032 Reset asserted mid-operation SHALL abandon any in-flight request; the first edge after rst rises SHALL act on that cycle's inputs normally.

Verification
REQ-033 Reset, then push 0x11, 0x22, 0x33 -> Count=3, Output=0x33; pop -> Output=0x22, Count=2.
REQ-034 Push 16 values 0x00..0x0F -> Full=1, Output=0x0F; 17th push of 0xAA -> Error=1, Count=16, Output=0x0F.
REQ-035 From empty, pop -> Error=1, Count=0, Output=0; then Clear -> Error=0; then push 0x5A -> Output=0x5A.
REQ-036 With Count=2 and top 0x22, Push+Pop with Value=0x99 -> Count=2, Output=0x99; pop -> Output equals prior second entry.
REQ-037 With Count=1 and top 0x44, Disable=1 -> Output=0; push 0x55 while disabled -> Count=2; drop Disable -> Output=0x55.
REQ-038 With Count=5 and Error=1, pulse rst low between edges -> outputs immediately 0/0/1/0/0; next push of 0x01 -> Count=1, Output=0x01.
